// File: rtl/alu_pkg.sv
// Shared types for the shader-core ALU: datapath word, memory/register sizing
// and the opcode encoding.
package GPU_Shader_pkg;
  typedef logic [31:0] word_t;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MEM_DEPTH = 128;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
endpackage

package opcode_pkg;
  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    MUL    = 4'd3,
    DIV    = 4'd4,
    MIN    = 4'd5,
    MAX    = 4'd6,
    AND    = 4'd7,
    OR     = 4'd8,
    XOR    = 4'd9,
    XNOR   = 4'd10,
    LOAD   = 4'd11,
    STORE  = 4'd12,
    MATADD = 4'd13,
    MATMUL = 4'd14
  } opcodes_t;
endpackage

// File: rtl/alu_mat_unit.sv
// Combinational packed-byte helpers: 4-lane 8-bit add and 2x2 8-bit matrix
// multiply (row-major, element [0][0] in bits [7:0]), all results mod 256.
module alu_mat_unit
  import GPU_Shader_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t lane_sum,
  output word_t mat_prod
);

  logic [7:0] a00, a01, a10, a11;
  logic [7:0] b00, b01, b10, b11;
  logic [7:0] c00, c01, c10, c11;

  assign {a11, a10, a01, a00} = a;
  assign {b11, b10, b01, b00} = b;

  assign lane_sum = {a[31:24] + b[31:24], a[23:16] + b[23:16],
                     a[15:8]  + b[15:8],  a[7:0]   + b[7:0]};

  assign c00 = a00 * b00 + a01 * b10;
  assign c01 = a00 * b01 + a01 * b11;
  assign c10 = a10 * b00 + a11 * b10;
  assign c11 = a10 * b01 + a11 * b11;

  assign mat_prod = {c11, c10, c01, c00};

endmodule

// File: rtl/alu.sv
// Single-issue integer ALU with registered register-file and data-memory write
// requests. Define ALU_MATRIX_OPS_EN to enable MATADD/MATMUL.
module alu
  import GPU_Shader_pkg::*;
  import opcode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  word_t             read_reg0,
  input  word_t             read_reg1,
  input  word_t             mem_read_data,
  input  opcodes_t          opcode,
  input  logic [10:0]       immd,
  output logic              reg_write_en,
  output int unsigned       reg_write_idx,
  output word_t             reg_write_data,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output word_t             mem_write_data
);

  logic              rwe_d;
  int unsigned       ridx_d;
  word_t             rdata_d;
  logic              mwe_d;
  logic [ADDR_W-1:0] maddr_d;
  word_t             mdata_d;

  word_t a, b;
  assign a = read_reg0;
  assign b = read_reg1;

`ifdef ALU_MATRIX_OPS_EN
  word_t lane_sum, mat_prod;

  alu_mat_unit u_mat (
    .a        (a),
    .b        (b),
    .lane_sum (lane_sum),
    .mat_prod (mat_prod)
  );
`endif

  always_comb begin
    rwe_d   = 1'b0;
    ridx_d  = '0;
    rdata_d = '0;
    mwe_d   = 1'b0;
    maddr_d = '0;
    mdata_d = '0;
    case (opcode)
      ADD:    begin rwe_d = 1'b1; rdata_d = a + b; end
      SUB:    begin rwe_d = 1'b1; rdata_d = a - b; end
      MUL:    begin rwe_d = 1'b1; rdata_d = a * b; end
      // Divide-by-zero returns all ones rather than trapping.
      DIV:    begin rwe_d = 1'b1; rdata_d = (b == '0) ? '1 : a / b; end
      MIN:    begin rwe_d = 1'b1; rdata_d = (a <= b) ? a : b; end
      MAX:    begin rwe_d = 1'b1; rdata_d = (a >= b) ? a : b; end
      AND:    begin rwe_d = 1'b1; rdata_d = a & b; end
      OR:     begin rwe_d = 1'b1; rdata_d = a | b; end
      XOR:    begin rwe_d = 1'b1; rdata_d = a ^ b; end
      XNOR:   begin rwe_d = 1'b1; rdata_d = ~(a ^ b); end
      LOAD:   begin rwe_d = 1'b1; rdata_d = mem_read_data; end
      STORE: begin
        mwe_d   = 1'b1;
        maddr_d = immd[ADDR_W-1:0];
        mdata_d = a;
      end
`ifdef ALU_MATRIX_OPS_EN
      MATADD: begin rwe_d = 1'b1; rdata_d = lane_sum; end
      MATMUL: begin rwe_d = 1'b1; rdata_d = mat_prod; end
`endif
      default: ;
    endcase
    if (rwe_d) ridx_d = {28'd0, immd[10:7]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_idx  <= '0;
      reg_write_data <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      reg_write_en   <= rwe_d;
      reg_write_idx  <= ridx_d;
      reg_write_data <= rdata_d;
      mem_write_en   <= mwe_d;
      mem_write_addr <= maddr_d;
      mem_write_data <= mdata_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the ALU; matrix-op expectations follow
// ALU_MATRIX_OPS_EN.
module tb_alu;
  import GPU_Shader_pkg::*;
  import opcode_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  word_t             read_reg0, read_reg1, mem_read_data;
  opcodes_t          opcode;
  logic [10:0]       immd;
  logic              reg_write_en;
  int unsigned       reg_write_idx;
  word_t             reg_write_data;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_write_addr;
  word_t             mem_write_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk            (clk),
    .rst            (rst),
    .read_reg0      (read_reg0),
    .read_reg1      (read_reg1),
    .mem_read_data  (mem_read_data),
    .opcode         (opcode),
    .immd           (immd),
    .reg_write_en   (reg_write_en),
    .reg_write_idx  (reg_write_idx),
    .reg_write_data (reg_write_data),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  typedef struct {
    string       name;
    opcodes_t    op;
    word_t       a;
    word_t       b;
    word_t       mem;
    logic [10:0] immd;
    logic        rwe;
    int unsigned idx;
    word_t       rdata;
    logic        mwe;
    int unsigned maddr;
    word_t       mdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic rwe, input int unsigned idx,
                           input word_t rdata, input logic mwe, input int unsigned maddr,
                           input word_t mdata);
    check({name, ".reg_write_en"},   64'(reg_write_en),   64'(rwe));
    check({name, ".reg_write_idx"},  64'(reg_write_idx),  64'(idx));
    check({name, ".reg_write_data"}, 64'(reg_write_data), 64'(rdata));
    check({name, ".mem_write_en"},   64'(mem_write_en),   64'(mwe));
    check({name, ".mem_write_addr"}, 64'(mem_write_addr), 64'(maddr));
    check({name, ".mem_write_data"}, 64'(mem_write_data), 64'(mdata));
  endtask

  task automatic apply(input opcodes_t op, input word_t a, input word_t b,
                       input word_t mem, input logic [10:0] im);
    opcode        = op;
    read_reg0     = a;
    read_reg1     = b;
    mem_read_data = mem;
    immd          = im;
    @(posedge clk);
    #1;
  endtask

  // Register op with destination idx: immd[10:7] = idx.
  task automatic add_reg(input string name, input opcodes_t op, input word_t a, input word_t b,
                         input int unsigned idx, input word_t exp);
    vecs.push_back('{name, op, a, b, 32'h0, 11'(idx << 7), 1'b1, idx, exp, 1'b0, 0, 32'h0});
  endtask

  task automatic add_idle(input string name, input opcodes_t op, input word_t a, input word_t b,
                          input logic [10:0] im);
    vecs.push_back('{name, op, a, b, 32'h0, im, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0});
  endtask

  initial begin
    rst = 1'b1;
    opcode = NOP; read_reg0 = '0; read_reg1 = '0; mem_read_data = '0; immd = '0;

    add_reg("add",      ADD,  32'd20, 32'd5, 3, 32'd25);
    add_reg("sub",      SUB,  32'd20, 32'd5, 3, 32'd15);
    add_reg("sub_wrap", SUB,  32'd5,  32'd20, 4, 32'hFFFF_FFF1);
    add_reg("mul",      MUL,  32'd6,  32'd7, 5, 32'd42);
    add_reg("mul_trunc",MUL,  32'h0001_0000, 32'h0001_0003, 15, 32'h0003_0000);
    add_reg("div",      DIV,  32'd100, 32'd4, 1, 32'd25);
    add_reg("div_zero", DIV,  32'd1,  32'd0, 6, 32'hFFFF_FFFF);
    add_reg("div_trunc",DIV,  32'd7,  32'd2, 7, 32'd3);
    add_reg("and",      AND,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 8, 32'h0000_0000);
    add_reg("or",       OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 9, 32'hFFFF_FFFF);
    add_reg("xor",      XOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 10, 32'hFFFF_FFFF);
    add_reg("xnor",     XNOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 11, 32'h0000_0000);
    add_reg("xnor2",    XNOR, 32'hFFFF_0000, 32'hFF00_FF00, 12, 32'hFF00_00FF);
    add_reg("min",      MIN,  32'd3, 32'd9, 2, 32'd3);
    add_reg("max",      MAX,  32'd3, 32'd9, 2, 32'd9);
    add_reg("min_tie",  MIN,  32'd5, 32'd5, 2, 32'd5);
    add_reg("min_rev",  MIN,  32'd9, 32'd3, 13, 32'd3);
    add_reg("max_big",  MAX,  32'h8000_0000, 32'd1, 14, 32'h8000_0000);
    vecs.push_back('{"load", LOAD, 32'd1, 32'd2, 32'd12345, 11'h100,
                     1'b1, 2, 32'd12345, 1'b0, 0, 32'h0});
    vecs.push_back('{"store", STORE, 32'd777, 32'd5, 32'd9, {4'd5, 7'd11},
                     1'b0, 0, 32'h0, 1'b1, 11, 32'd777});
    add_idle("nop_after_store", NOP, 32'd1, 32'd2, 11'h7FF);
    add_idle("undef_op", opcodes_t'(4'd15), 32'd8, 32'd9, 11'h3C5);
`ifdef ALU_MATRIX_OPS_EN
    add_reg("matadd",       MATADD, 32'h0102_0304, 32'hFF01_0101, 1, 32'h0003_0405);
    add_reg("matmul_ident", MATMUL, 32'h0100_0001, 32'h0403_0201, 2, 32'h0403_0201);
    add_reg("matmul",       MATMUL, 32'h0403_0201, 32'h0807_0605, 3, 32'h322B_1613);
`else
    add_idle("matadd_off", MATADD, 32'h0102_0304, 32'hFF01_0101, 11'h080);
    add_idle("matmul_off", MATMUL, 32'h0100_0001, 32'h0403_0201, 11'h100);
`endif

    apply(ADD, 32'd20, 32'd5, 32'd0, 11'h180);
    apply(ADD, 32'd20, 32'd5, 32'd0, 11'h180);
    check_all("reset_state", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mem, vecs[i].immd);
      check_all(vecs[i].name, vecs[i].rwe, vecs[i].idx, vecs[i].rdata,
                vecs[i].mwe, vecs[i].maddr, vecs[i].mdata);
    end

    // Reset arriving mid-stream must override the op in flight.
    apply(ADD, 32'd20, 32'd5, 32'd0, 11'h180);
    check_all("pre_reset_add", 1'b1, 3, 32'd25, 1'b0, 0, 32'h0);
    rst = 1'b1;
    apply(ADD, 32'd20, 32'd5, 32'd0, 11'h180);
    check_all("reset_over_add", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    apply(STORE, 32'd777, 32'd0, 32'd0, 11'd11);
    check_all("reset_over_store", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    rst = 1'b0;
    apply(SUB, 32'd20, 32'd5, 32'd0, 11'h400);
    check_all("post_reset_sub", 1'b1, 8, 32'd15, 1'b0, 0, 32'h0);
    apply(STORE, 32'hDEAD_BEEF, 32'd0, 32'd0, 11'h07F);
    check_all("store_max_addr", 1'b0, 0, 32'h0, 1'b1, 127, 32'hDEAD_BEEF);
    apply(NOP, 32'd0, 32'd0, 32'd0, 11'h0);
    check_all("nop_idle", 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Single-issue integer ALU for the mini GPU shader core.
- Takes two register operands, a memory read word, an opcode and an 11-bit immediate.
- Produces one registered register-file write request and one registered data-memory write request per cycle.
- Sits between the register file / data memory read ports and their write ports.

Parameters:
- WORD_W, 32 (from the word_t package type): datapath width.
- MEM_DEPTH, 128 (package constant): data memory depth. $clog2(MEM_DEPTH) must be ≤ 7.
- NUM_REGS, 16 (package constant): register file depth.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- read_reg0  in  32  operand A, and the store value for STORE.
- read_reg1  in  32  operand B.
- mem_read_data  in  32  data memory read word, used by LOAD.
- opcode  in  opcodes_t  operation select.
- immd  in  11  immediate: [10:7] destination register, [$clog2(MEM_DEPTH)-1:0] memory address.
- reg_write_en  out  1  register write strobe.
- reg_write_idx  out  32 (int unsigned)  destination register index.
- reg_write_data  out  32  register write data.
- mem_write_en  out  1  memory write strobe.
- mem_write_addr  out  $clog2(MEM_DEPTH)  memory write address.
- mem_write_data  out  32  memory write data.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- On rst at a rising edge, all outputs are 0. Reset has priority over any opcode in flight.
- Latency: result computed combinationally and registered on the rising clk edge; visible 1 cycle after inputs are presented. Fully pipelined, one op per cycle, no handshake, no stall.
- Every output is rewritten every cycle. Idle cycles drive both enables to 0 and all data/index/address outputs to 0.
- All arithmetic is unsigned, modulo 2^32.
- reg_write_idx = zero-extended immd[10:7] for every register-writing op.
- ADD: A+B.
- SUB: A-B, wraps.
- MUL: low 32 bits of A*B.
- DIV: A/B, truncating.
  - If B == 0: result is 32'hFFFF_FFFF, reg_write_en still 1.
- MIN / MAX: unsigned compare. On a tie, the result is A.
- AND, OR, XOR, XNOR: bitwise.
- LOAD: reg_write_data = mem_read_data; reg_write_en = 1. The memory read address is driven upstream from immd.
- Register-writing ops (ADD through XNOR, LOAD, MATADD, MATMUL): reg_write_en = 1, mem_write_en = 0.
- STORE: mem_write_en = 1, mem_write_addr = immd[$clog2(MEM_DEPTH)-1:0], mem_write_data = A, reg_write_en = 0.
- MATADD (only with feature): A and B are each four 8-bit lanes. Lane-wise add, each lane wrapping mod 256.
- MATMUL (only with feature): A and B are each a 2x2 matrix of 8-bit elements, row-major, element [0][0] in bits [7:0]. Result is A×B with each element truncated to 8 bits.
- NOP and any undefined opcode encoding: both enables 0, outputs 0.

Optional Feature:
- Macro: ALU_MATRIX_OPS_EN.
- Defined: MATADD and MATMUL are implemented as described above.
- Undefined: MATADD and MATMUL decode as NOP (both enables 0) and no matrix logic is synthesized.

Decomposition:
- GPU_Shader_pkg holds word_t (logic [31:0]), MEM_DEPTH and NUM_REGS.
- opcode_pkg holds the opcodes_t enum: NOP, ADD, SUB, MUL, DIV, MIN, MAX, AND, OR, XOR, XNOR, LOAD, STORE, MATADD, MATMUL, encoded 0..14 in 4 bits.
- One sub-module, alu_mat_unit: combinational 4x8-bit lane adder and 2x2 matrix multiplier. Instantiated only under ALU_MATRIX_OPS_EN.

Test Plan:
- Scalar arithmetic, one cycle after each input set:
  - A=20, B=5, ADD, immd[10:7]=3 → reg_write_en=1, idx=3, data=25.
  - SUB on the same operands → data=15.
  - A=6, B=7, MUL → 42.
- Division:
  - A=100, B=4, DIV → 25.
  - A=1, B=0, DIV → 32'hFFFF_FFFF with reg_write_en=1.
- Bitwise, A=F0F0F0F0, B=0F0F0F0F:
  - AND → 00000000.
  - OR → FFFFFFFF.
  - XOR → FFFFFFFF.
  - XNOR → 00000000.
- Compare: MIN(3,9) → 3; MAX(3,9) → 9; MIN(5,5) → 5.
- LOAD: mem_read_data=12345 → reg_write_data=12345, mem_write_en=0.
- STORE: A=777, immd=11 → mem_write_en=1, addr=11, data=777, reg_write_en=0.
- Reset mid-stream: assert rst while ADD is applied → all outputs 0 next cycle.
- NOP: all outputs 0 next cycle.
- Matrix ops (with ALU_MATRIX_OPS_EN):
  - MATADD A=01020304, B=FF010101 → 00030405.
  - MATMUL identity A=01000001, B=04030201 → 04030201.
